audio_sample_scheduler: RTL and testbench

//  Sequences the PWM sampler's sample updates. On each sampler sample-request pulse it fetches 10-bit codes from up to two sources.
//  - Source 0: synth NCO. Source 1: CPU sample FIFO.
//  - Per cfg_mode it selects one source, mixes both, or outputs silence.
//  - It then attenuates around midscale and presents exactly one synth_valid pulse to the sampler.
//  - It also counts source underruns and request overruns for the CPU status regs.

---
 rtl/audio_pkg.sv | 31 +++
 rtl/audio_code_scaler.sv | 40 ++++
 rtl/audio_sample_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_audio_sample_scheduler.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants, mode encodings and FSM state type for the audio sample scheduler.
package audio_pkg;

    localparam logic [9:0] MIDSCALE          = 10'd512;
    localparam int         CYCLES_PER_SAMPLE = 2500;

    localparam logic [1:0] MODE_SRC0    = 2'b00;
    localparam logic [1:0] MODE_SRC1    = 2'b01;
    localparam logic [1:0] MODE_MIX     = 2'b10;
    localparam logic [1:0] MODE_SILENCE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_CALC = 2'd2,
        ST_SEND = 2'd3
    } sched_state_t;

    // Bit N set when source N has to be fetched for the given mode.
    function automatic logic [1:0] needed_sources(input logic [1:0] mode);
        logic [1:0] mask;
        case (mode)
            MODE_SRC0: mask = 2'b01;
            MODE_SRC1: mask = 2'b10;
            MODE_MIX:  mask = 2'b11;
            default:   mask = 2'b00;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/audio_code_scaler.sv
// Combinational source select / mix followed by attenuation about midscale.
module audio_code_scaler
    import audio_pkg::*;
(
    input  logic [9:0] a,
    input  logic [9:0] b,
    input  logic [1:0] mode,
    input  logic [2:0] vol_shift,
    input  logic       mute,
    output logic [9:0] code
);

    logic [10:0]        sum;
    logic [9:0]         mixed;
    logic signed [10:0] centered;
    logic signed [10:0] shifted;
    logic signed [10:0] recentred;

    // Pick or average the sources, then shrink the signed offset from midscale.
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
        case (mode)
            MODE_SRC0: mixed = a;
            MODE_SRC1: mixed = b;
            MODE_MIX:  mixed = sum[10:1];
            default:   mixed = MIDSCALE;
        endcase
        // Offset is in -512..511, so an arithmetic shift can only move it toward
        // zero and the recentred value always stays within 0..1023.
        centered  = $signed({1'b0, mixed}) - 11'sd512;
        shifted   = centered >>> vol_shift;
        recentred = shifted + 11'sd512;
        if (mute || (mode == MODE_SILENCE)) begin
            code = MIDSCALE;
        end else begin
            code = recentred[9:0];
        end
    end

endmodule

// File: rtl/audio_sample_scheduler.sv
// Per-sample fetch / mix / attenuate sequencer feeding the PWM sampler.
module audio_sample_scheduler
    import audio_pkg::*;
#(
    parameter int TIMEOUT = 2048,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_tick,
    input  logic [1:0]       cfg_mode,
    input  logic [2:0]       cfg_vol_shift,
    input  logic             cfg_mute,
    input  logic             src0_valid,
    input  logic [9:0]       src0_code,
    output logic             src0_ready,
    input  logic             src1_valid,
    input  logic [9:0]       src1_code,
    output logic             src1_ready,
    output logic             synth_valid,
    output logic [9:0]       scaled_synth_code,
    output logic [CNT_W-1:0] underrun_cnt,
    output logic [CNT_W-1:0] overrun_cnt,
    output logic             busy
);

    localparam int               TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    sched_state_t     state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [2:0]       shift_q, shift_d;
    logic             mute_q, mute_d;
    logic [1:0]       need_q, need_d;
    logic [1:0]       got_q, got_d;
    logic [1:0]       src_ready_q, src_ready_d;
    logic [9:0]       cap0_q, cap0_d;
    logic [9:0]       cap1_q, cap1_d;
    logic [9:0]       hold0_q, hold0_d;
    logic [9:0]       hold1_q, hold1_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             synth_valid_q, synth_valid_d;
    logic [9:0]       code_q, code_d;
    logic [CNT_W-1:0] underrun_q, underrun_d;
    logic [CNT_W-1:0] overrun_q, overrun_d;

    logic [1:0] src_valid;
    logic [1:0] src_fire;
    logic [1:0] got_now;
    logic [1:0] missing;
    logic [9:0] operand_a;
    logic [9:0] operand_b;
    logic [9:0] scaled_code;

    assign src_valid = {src1_valid, src0_valid};

    // A source is consumed only when its registered ready meets its valid.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fire
        assign src_fire[gi] = src_valid[gi] & src_ready_q[gi];
    end

    assign got_now = got_q | src_fire;
    assign missing = need_q & ~got_now;

    // Fresh captures win; an uncaptured (or unneeded) source falls back to its hold reg.
    assign operand_a = got_q[0] ? cap0_q : hold0_q;
    assign operand_b = got_q[1] ? cap1_q : hold1_q;

    audio_code_scaler u_scaler (
        .a         (operand_a),
        .b         (operand_b),
        .mode      (mode_q),
        .vol_shift (shift_q),
        .mute      (mute_q),
        .code      (scaled_code)
    );

    // Next-state, handshake, arithmetic capture and counter logic.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        shift_d       = shift_q;
        mute_d        = mute_q;
        need_d        = need_q;
        got_d         = got_q;
        src_ready_d   = 2'b00;
        cap0_d        = src_fire[0] ? src0_code : cap0_q;
        cap1_d        = src_fire[1] ? src1_code : cap1_q;
        hold0_d       = hold0_q;
        hold1_d       = hold1_q;
        timer_d       = timer_q;
        synth_valid_d = 1'b0;
        code_d        = code_q;
        underrun_d    = underrun_q;
        overrun_d     = overrun_q;

        // A request arriving mid-sample is dropped but recorded.
        if (sample_tick && (state_q != ST_IDLE) && (overrun_q != {CNT_W{1'b1}})) begin
            overrun_d = overrun_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    mode_d  = cfg_mode;
                    shift_d = cfg_vol_shift;
                    mute_d  = cfg_mute;
                    timer_d = '0;
                    got_d   = 2'b00;
                    if ((cfg_mode == MODE_SILENCE) || cfg_mute) begin
                        need_d  = 2'b00;
                        state_d = ST_CALC;
                    end else begin
                        need_d      = needed_sources(cfg_mode);
                        src_ready_d = needed_sources(cfg_mode);
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                got_d   = got_now;
                timer_d = timer_q + 1'b1;
                if (missing == 2'b00) begin
                    state_d = ST_CALC;
                end else if (timer_q == TMR_LAST) begin
                    state_d = ST_CALC;
                    if (underrun_q != {CNT_W{1'b1}}) begin
                        underrun_d = underrun_q + 1'b1;
                    end
                end else begin
                    src_ready_d = missing;
                end
            end
            ST_CALC: begin
                code_d        = scaled_code;
                hold0_d       = operand_a;
                hold1_d       = operand_b;
                synth_valid_d = 1'b1;
                state_d       = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any sample in flight without a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_SRC0;
            shift_q       <= 3'd0;
            mute_q        <= 1'b0;
            need_q        <= 2'b00;
            got_q         <= 2'b00;
            src_ready_q   <= 2'b00;
            cap0_q        <= MIDSCALE;
            cap1_q        <= MIDSCALE;
            hold0_q       <= MIDSCALE;
            hold1_q       <= MIDSCALE;
            timer_q       <= '0;
            synth_valid_q <= 1'b0;
            code_q        <= MIDSCALE;
            underrun_q    <= '0;
            overrun_q     <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            shift_q       <= shift_d;
            mute_q        <= mute_d;
            need_q        <= need_d;
            got_q         <= got_d;
            src_ready_q   <= src_ready_d;
            cap0_q        <= cap0_d;
            cap1_q        <= cap1_d;
            hold0_q       <= hold0_d;
            hold1_q       <= hold1_d;
            timer_q       <= timer_d;
            synth_valid_q <= synth_valid_d;
            code_q        <= code_d;
            underrun_q    <= underrun_d;
            overrun_q     <= overrun_d;
        end
    end

    assign src0_ready        = src_ready_q[0];
    assign src1_ready        = src_ready_q[1];
    assign synth_valid       = synth_valid_q;
    assign scaled_synth_code = code_q;
    assign underrun_cnt      = underrun_q;
    assign overrun_cnt       = overrun_q;
    assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Scoreboard bench for audio_sample_scheduler: stimulus pushes expected pulses,
// a negedge monitor pops and compares them against synth_valid / scaled_synth_code.
module tb_audio_sample_scheduler;

    localparam int TIMEOUT = 2048;
    localparam int CNT_W   = 16;

    localparam logic [1:0] M_SRC0 = 2'b00;
    localparam logic [1:0] M_SRC1 = 2'b01;
    localparam logic [1:0] M_MIX  = 2'b10;
    localparam logic [1:0] M_SIL  = 2'b11;

    logic             clk;
    logic             rst;
    logic             sample_tick;
    logic [1:0]       cfg_mode;
    logic [2:0]       cfg_vol_shift;
    logic             cfg_mute;
    logic             src0_valid;
    logic [9:0]       src0_code;
    logic             src0_ready;
    logic             src1_valid;
    logic [9:0]       src1_code;
    logic             src1_ready;
    logic             synth_valid;
    logic [9:0]       scaled_synth_code;
    logic [CNT_W-1:0] underrun_cnt;
    logic [CNT_W-1:0] overrun_cnt;
    logic             busy;

    audio_sample_scheduler #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .sample_tick       (sample_tick),
        .cfg_mode          (cfg_mode),
        .cfg_vol_shift     (cfg_vol_shift),
        .cfg_mute          (cfg_mute),
        .src0_valid        (src0_valid),
        .src0_code         (src0_code),
        .src0_ready        (src0_ready),
        .src1_valid        (src1_valid),
        .src1_code         (src1_code),
        .src1_ready        (src1_ready),
        .synth_valid       (synth_valid),
        .scaled_synth_code (scaled_synth_code),
        .underrun_cnt      (underrun_cnt),
        .overrun_cnt       (overrun_cnt),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [9:0] code;
        int         cmin;
        int         cmax;
        int         tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: every synth_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && synth_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL unexpected_pulse: synth_valid at cycle %0d code %0d, expected no pulse",
                         cyc, scaled_synth_code);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("sample%0d_code", mon_e.tag), int'(scaled_synth_code), int'(mon_e.code));
                n_total++;
                if (cyc < mon_e.cmin || cyc > mon_e.cmax) begin
                    n_bad++;
                    $display("FAIL sample%0d_cycle: pulse at cycle %0d expected %0d..%0d",
                             mon_e.tag, cyc, mon_e.cmin, mon_e.cmax);
                end else begin
                    $display("ok   sample%0d_cycle: %0d", mon_e.tag, cyc);
                end
            end
        end
    end

    // Issue one tick with the given config; optionally queue the expected pulse
    // at cycle offsets lo..hi from the tick cycle. Returns at the negedge of cycle 1.
    task automatic start_sample(input logic [1:0] mode, input logic [2:0] sh, input logic mute,
                                input logic push, input logic [9:0] code, input int lo,
                                input int hi, input int tag, output int k);
        exp_t t;
        @(negedge clk);
        cfg_mode      = mode;
        cfg_vol_shift = sh;
        cfg_mute      = mute;
        sample_tick   = 1'b1;
        k             = cyc;
        if (push) begin
            t.code = code;
            t.cmin = k + lo;
            t.cmax = k + hi;
            t.tag  = tag;
            exp_q.push_back(t);
        end
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    // Bounded wait for the scheduler to return to IDLE with all pulses seen.
    task automatic wait_done(input string name);
        int i;
        i = 0;
        while (i < TIMEOUT + 100 && !(busy === 1'b0 && exp_q.size() == 0)) begin
            @(negedge clk);
            i++;
        end
        if (i >= TIMEOUT + 100) begin
            n_total++;
            n_bad++;
            $display("FAIL %s_done: busy=%0b pending=%0d after %0d cycles, required idle",
                     name, busy, exp_q.size(), i);
        end
        src0_valid = 1'b0;
        src1_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst           = 1'b1;
        sample_tick   = 1'b0;
        cfg_mode      = M_SRC0;
        cfg_vol_shift = 3'd0;
        cfg_mute      = 1'b0;
        src0_valid    = 1'b0;
        src0_code     = 10'd0;
        src1_valid    = 1'b0;
        src1_code     = 10'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1. Reset state, no tick.
        repeat (5) @(negedge clk);
        check("reset_code", int'(scaled_synth_code), 512);
        check("reset_valid", int'(synth_valid), 0);
        check("reset_rdy0", int'(src0_ready), 0);
        check("reset_rdy1", int'(src1_ready), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_underrun", int'(underrun_cnt), 0);
        check("reset_overrun", int'(overrun_cnt), 0);

        // 2. SRC0 code 800, shift 0; config changed after the tick must not matter.
        src0_valid = 1'b1; src0_code = 10'd800;
        start_sample(M_SRC0, 3'd0, 1'b0, 1'b1, 10'd800, 3, 3, 2, k);
        check("t2_rdy0_c1", int'(src0_ready), 1);
        check("t2_rdy1_c1", int'(src1_ready), 0);
        cfg_mode = M_SIL;
        @(negedge clk);
        check("t2_rdy0_c2", int'(src0_ready), 0);
        wait_done("t2");

        // 3. SRC1 never valid -> timeout, reset-time hold value 512.
        start_sample(M_SRC1, 3'd0, 1'b0, 1'b1, 10'd512, TIMEOUT + 1, TIMEOUT + 4, 3, k);
        check("t3_rdy1_c1", int'(src1_ready), 1);
        wait_done("t3");
        check("t3_underrun", int'(underrun_cnt), 1);

        // 4. MIX with src0=700 fresh and src1 timing out: (700+512)>>1 = 606.
        src0_valid = 1'b1; src0_code = 10'd700;
        start_sample(M_MIX, 3'd0, 1'b0, 1'b1, 10'd606, TIMEOUT + 1, TIMEOUT + 4, 4, k);
        wait_done("t4");
        check("t4_underrun", int'(underrun_cnt), 2);

        // 5. MIX full scale: 1023+1023 -> 1023.
        src0_valid = 1'b1; src0_code = 10'd1023;
        src1_valid = 1'b1; src1_code = 10'd1023;
        start_sample(M_MIX, 3'd0, 1'b0, 1'b1, 10'd1023, 3, 3, 5, k);
        check("t5_rdy0_c1", int'(src0_ready), 1);
        check("t5_rdy1_c1", int'(src1_ready), 1);
        wait_done("t5");

        // 6. MIX 100/300 shift 1: m=200, v=-312>>>1=-156 -> 356.
        src0_valid = 1'b1; src0_code = 10'd100;
        src1_valid = 1'b1; src1_code = 10'd300;
        start_sample(M_MIX, 3'd1, 1'b0, 1'b1, 10'd356, 3, 3, 6, k);
        wait_done("t6");

        // 7. Extremes with maximum shift: 0 -> -512>>>7=-4 -> 508; 1023 -> 511>>>7=3 -> 515.
        src0_valid = 1'b1; src0_code = 10'd0;
        start_sample(M_SRC0, 3'd7, 1'b0, 1'b1, 10'd508, 3, 3, 7, k);
        wait_done("t7a");
        src1_valid = 1'b1; src1_code = 10'd1023;
        start_sample(M_SRC1, 3'd7, 1'b0, 1'b1, 10'd515, 3, 3, 8, k);
        wait_done("t7b");

        // 8. Second tick during cycle 2 of a sample: one pulse, overrun counted.
        src0_valid = 1'b1; src0_code = 10'd800;
        start_sample(M_SRC0, 3'd0, 1'b0, 1'b1, 10'd800, 3, 3, 9, k);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        wait_done("t8");
        check("t8_overrun", int'(overrun_cnt), 1);
        check("t8_underrun", int'(underrun_cnt), 2);

        // 9. Mute with a valid source present: no ready, pulse at cycle 2, code 512.
        src0_valid = 1'b1; src0_code = 10'd900;
        start_sample(M_SRC0, 3'd0, 1'b1, 1'b1, 10'd512, 2, 2, 10, k);
        check("t9_rdy0_c1", int'(src0_ready), 0);
        wait_done("t9");

        // 10. SILENCE mode: pulse at cycle 2, code 512.
        src1_valid = 1'b1; src1_code = 10'd50;
        start_sample(M_SIL, 3'd0, 1'b0, 1'b1, 10'd512, 2, 2, 11, k);
        check("t10_rdy1_c1", int'(src1_ready), 0);
        wait_done("t10");

        // 11. Reset while in REQ: idle next cycle, no pulse, everything cleared.
        start_sample(M_SRC1, 3'd0, 1'b0, 1'b0, 10'd0, 0, 0, 0, k);
        check("t11_rdy1_c1", int'(src1_ready), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t11_busy", int'(busy), 0);
        check("t11_rdy1", int'(src1_ready), 0);
        check("t11_code", int'(scaled_synth_code), 512);
        check("t11_underrun", int'(underrun_cnt), 0);
        check("t11_overrun", int'(overrun_cnt), 0);
        repeat (6) @(negedge clk);
        src1_valid = 1'b1; src1_code = 10'd300;
        start_sample(M_SRC1, 3'd0, 1'b0, 1'b1, 10'd300, 3, 3, 12, k);
        wait_done("t11");

        // 12. SRC1 timeout now reuses the last captured value 300.
        start_sample(M_SRC1, 3'd0, 1'b0, 1'b1, 10'd300, TIMEOUT + 1, TIMEOUT + 4, 13, k);
        wait_done("t12");
        check("t12_underrun", int'(underrun_cnt), 1);

        check("pending_expectations", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
